// File: rtl/serial_shift_pkg.sv
// Shared types for the serial shift unit: sequencer state encoding and shift direction codes.
// Pure declarations; no logic, no latency, no flow control.
package serial_shift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/serial_shift_unit_if.sv
// Command/data bundle of the serial shift unit; master issues commands, slave owns q and status.
// No handshake: every command is sampled on the next rising clk edge, busy flags ignored commands.
interface serial_shift_unit_if #(
  parameter int WIDTH = 8
);
  logic             clr;
  logic             start;
  logic             par_load;
  logic             shift_en;
  logic             dir;
  logic             extend;
  logic             serial_in;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] q;
  logic             serial_out;
  logic             busy;
  logic             done;

  modport master (
    output clr, start, par_load, shift_en, dir, extend, serial_in, data_in,
    input  q, serial_out, busy, done
  );

  modport slave (
    input  clr, start, par_load, shift_en, dir, extend, serial_in, data_in,
    output q, serial_out, busy, done
  );
endinterface

// File: rtl/load_seq_ctrl.sv
// Serial-load sequencer: IDLE/LOAD/DONE FSM plus bit counter; busy/done decoded from state.
// One bit per cycle for WIDTH cycles after start; start/par_load are ignored while loading.
module load_seq_ctrl
  import serial_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             start,
  input  logic             par_load,
  output logic             busy,
  output logic             done,
  output logic             load_active,
  output logic [CNT_W-1:0] bit_idx
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (clr) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          // par_load outranks start; DONE always falls back to IDLE otherwise
          if (!par_load && start) begin
            state_nxt = ST_LOAD;
            cnt_nxt   = '0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (cnt == CNT_LAST) begin
            state_nxt = ST_DONE;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign busy        = (state == ST_LOAD);
  assign done        = (state == ST_DONE);
  assign load_active = (state == ST_LOAD);
  assign bit_idx     = cnt;

endmodule

// File: rtl/serial_shift_unit.sv
// Operand/accumulator register: serial load (MSB- or LSB-first), parallel load, shifts with fill/sign-extend.
// Parallel load and shifts take 1 cycle; serial load takes WIDTH cycles after start, commands ignored meanwhile.
module serial_shift_unit
  import serial_shift_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  serial_shift_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] shadow;
  logic             load_active;
  logic [CNT_W-1:0] bit_idx;
  logic [CNT_W-1:0] sel_idx;
  logic             load_bit;
  logic             right_fill;

  load_seq_ctrl #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .clr         (bus.clr),
    .start       (bus.start),
    .par_load    (bus.par_load),
    .busy        (bus.busy),
    .done        (bus.done),
    .load_active (load_active),
    .bit_idx     (bit_idx)
  );

  // MSB-first walks the shadow word from the top, LSB-first from the bottom
  assign sel_idx    = MSB_FIRST ? (CNT_W'(WIDTH - 1) - bit_idx) : bit_idx;
  assign load_bit   = shadow[sel_idx];
  assign right_fill = bus.extend ? q_r[WIDTH-1] : bus.serial_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_r    <= '0;
      shadow <= '0;
    end else if (bus.clr) begin
      q_r <= '0;
    end else if (load_active) begin
      if (MSB_FIRST) begin
        q_r <= {q_r[WIDTH-2:0], load_bit};
      end else begin
        q_r <= {load_bit, q_r[WIDTH-1:1]};
      end
    end else if (bus.par_load) begin
      q_r <= bus.data_in;
    end else if (bus.start) begin
      shadow <= bus.data_in;
      q_r    <= '0;
    end else if (bus.shift_en) begin
      if (bus.dir == DIR_RIGHT) begin
        q_r <= {right_fill, q_r[WIDTH-1:1]};
      end else begin
        q_r <= {q_r[WIDTH-2:0], bus.serial_in};
      end
    end
  end

  assign bus.q          = q_r;
  assign bus.serial_out = (bus.dir == DIR_LEFT) ? q_r[WIDTH-1] : q_r[0];

endmodule
